// File: rtl/brp_predictor_pkg.sv
// Shared types for the IF-stage branch predictor: prediction word, BTB entry,
// counter constants and the PC field helpers used by lookup and update.
package brp_predictor_pkg;

  typedef enum bit {BRP_BRANCH = 1'b0, BRP_JUMP = 1'b1} brp_kind_t;

  typedef struct packed {
    logic        predicted;
    logic        prediction;
    logic        mispredicted;
    logic [31:0] brp_target;
    logic [31:0] brp_alt;
  } rv32i_brp_word;

  // Tag is held at its widest possible size; narrower configurations leave the MSBs zero.
  typedef struct packed {
    logic        valid;
    logic [29:0] tag;
    logic [31:0] target;
    brp_kind_t   kind;
  } btb_entry_t;

  typedef enum logic [1:0] {CTR_HOLD, CTR_INC, CTR_DEC, CTR_LOAD} ctr_op_t;

  localparam logic [1:0] BRP_CTR_INIT  = 2'b01;
  localparam logic [1:0] BRP_CTR_ALLOC = 2'b10;

  function automatic logic [29:0] pc_tag(input logic [31:0] pc, input int idx_bits);
    logic [31:0] sh;
    sh = pc >> (idx_bits + 2);
    return sh[29:0];
  endfunction

endpackage

// File: rtl/brp_predictor_sat_ctr.sv
// brp_sat_ctr2: next-state function of a 2-bit saturating counter (hold/inc/dec/load).
module brp_sat_ctr2
  import brp_predictor_pkg::*;
(
  input  logic [1:0] ctr,
  input  ctr_op_t    op,
  input  logic [1:0] load_val,
  output logic [1:0] ctr_nxt
);

  // Saturating next-count selection
  always_comb begin
    ctr_nxt = ctr;
    case (op)
      CTR_INC: begin
        if (ctr != 2'b11) ctr_nxt = ctr + 2'd1;
        else              ctr_nxt = ctr;
      end
      CTR_DEC: begin
        if (ctr != 2'b00) ctr_nxt = ctr - 2'd1;
        else              ctr_nxt = ctr;
      end
      CTR_LOAD: ctr_nxt = load_val;
      CTR_HOLD: ctr_nxt = ctr;
      default:  ctr_nxt = ctr;
    endcase
  end

endmodule

// File: rtl/brp_predictor.sv
// Direct-mapped BTB + bimodal predictor: same-cycle lookup of if_pc, trained by
// resolved outcomes from EX, with branch/misprediction performance counters.
module brp_predictor
  import brp_predictor_pkg::*;
#(
  parameter int IDX_BITS = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   if_pc,
  output rv32i_brp_word brp_o,
  input  logic          ex_upd_valid,
  input  logic [31:0]   ex_upd_pc,
  input  logic          ex_upd_is_jump,
  input  logic          ex_upd_taken,
  input  logic [31:0]   ex_upd_target,
  input  logic          ex_upd_mispred,
  output logic [31:0]   perf_br_cnt,
  output logic [31:0]   perf_miss_cnt
);

  localparam int ENTRIES = 1 << IDX_BITS;

  btb_entry_t btb_r [ENTRIES];
  logic [1:0] ctr_r [ENTRIES];

  logic [IDX_BITS-1:0] lk_idx_s;
  logic [29:0]         lk_tag_s;
  logic                lk_hit_s;
  logic                lk_taken_s;
  logic [31:0]         lk_seq_s;
  btb_entry_t          lk_ent_s;

  logic [IDX_BITS-1:0] up_idx_s;
  logic [29:0]         up_tag_s;
  logic                up_hit_s;
  ctr_op_t             up_op_s;
  logic [1:0]          up_ctr_nxt_s;

  assign lk_idx_s = if_pc[IDX_BITS+1:2];
  assign lk_tag_s = pc_tag(if_pc, IDX_BITS);
  assign lk_ent_s = btb_r[lk_idx_s];
  assign lk_seq_s = if_pc + 32'd4;

  // Lookup reads table state as of the last edge; no bypass from a concurrent update
  always_comb begin
    lk_hit_s   = lk_ent_s.valid & (lk_ent_s.tag == lk_tag_s);
    lk_taken_s = lk_hit_s & ((lk_ent_s.kind == BRP_JUMP) | ctr_r[lk_idx_s][1]);
    brp_o.predicted    = lk_hit_s;
    brp_o.prediction   = lk_taken_s;
    brp_o.mispredicted = 1'b0;
    if (lk_taken_s) begin
      brp_o.brp_target = lk_ent_s.target;
      brp_o.brp_alt    = lk_seq_s;
    end else if (lk_hit_s) begin
      brp_o.brp_target = lk_seq_s;
      brp_o.brp_alt    = lk_ent_s.target;
    end else begin
      brp_o.brp_target = lk_seq_s;
      brp_o.brp_alt    = lk_seq_s;
    end
  end

  assign up_idx_s = ex_upd_pc[IDX_BITS+1:2];
  assign up_tag_s = pc_tag(ex_upd_pc, IDX_BITS);
  assign up_hit_s = btb_r[up_idx_s].valid & (btb_r[up_idx_s].tag == up_tag_s);

  // Counter action for the resolved instruction; not-taken misses never allocate
  always_comb begin
    up_op_s = CTR_HOLD;
    if (up_hit_s) begin
      if (ex_upd_taken) up_op_s = CTR_INC;
      else              up_op_s = CTR_DEC;
    end else begin
      if (ex_upd_taken) up_op_s = CTR_LOAD;
      else              up_op_s = CTR_HOLD;
    end
  end

  brp_sat_ctr2 u_sat_ctr (
    .ctr      (ctr_r[up_idx_s]),
    .op       (up_op_s),
    .load_val (BRP_CTR_ALLOC),
    .ctr_nxt  (up_ctr_nxt_s)
  );

  // Table training and perf counters; reset drops any update in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_r[i].valid <= 1'b0;
        ctr_r[i]       <= BRP_CTR_INIT;
      end
      perf_br_cnt   <= 32'd0;
      perf_miss_cnt <= 32'd0;
    end else if (ex_upd_valid) begin
      if (ex_upd_taken) begin
        btb_r[up_idx_s].valid  <= 1'b1;
        btb_r[up_idx_s].tag    <= up_tag_s;
        btb_r[up_idx_s].target <= ex_upd_target;
        btb_r[up_idx_s].kind   <= ex_upd_is_jump ? BRP_JUMP : BRP_BRANCH;
      end
      ctr_r[up_idx_s] <= up_ctr_nxt_s;
      perf_br_cnt     <= perf_br_cnt + 32'd1;
      if (ex_upd_mispred) perf_miss_cnt <= perf_miss_cnt + 32'd1;
    end
  end

endmodule
